// File: rtl/procyon_core_pkg.sv
// Shared types and helpers for the procyon core: RAT controller state encoding
// and register-map index sizing.
package procyon_core_pkg;

    // Recovery sequencer states for the RAT controller
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } rat_ctrl_state_t;

    // Index width of a register map with the given number of entries
    function automatic int regmap_idx_width(input int depth);
        return $clog2(depth);
    endfunction

    localparam int OPTN_REGMAP_DEPTH = 32;
    localparam int REGMAP_IDX_WIDTH  = regmap_idx_width(OPTN_REGMAP_DEPTH);

endpackage

// File: rtl/procyon_rat_lookup.sv
// One source-operand read port of the RAT: entry mux, x0 forced to a ready
// zero, and same-cycle bypass of a retiring value whose tag still matches.
module procyon_rat_lookup
    import procyon_core_pkg::*;
#(
    parameter int OPTN_DATA_WIDTH    = 32,
    parameter int OPTN_ROB_IDX_WIDTH = 5,
    parameter int OPTN_REGMAP_DEPTH  = 32,
    localparam int IDX_W = regmap_idx_width(OPTN_REGMAP_DEPTH)
) (
    input  logic [IDX_W-1:0]                                i_rs,
    input  logic [OPTN_REGMAP_DEPTH*OPTN_DATA_WIDTH-1:0]    i_rat_data,
    input  logic [OPTN_REGMAP_DEPTH*OPTN_ROB_IDX_WIDTH-1:0] i_rat_tag,
    input  logic [OPTN_REGMAP_DEPTH-1:0]                    i_rat_rdy,
    input  logic                                            i_retire_en,
    input  logic [IDX_W-1:0]                                i_retire_rdest,
    input  logic [OPTN_DATA_WIDTH-1:0]                      i_retire_data,
    input  logic [OPTN_ROB_IDX_WIDTH-1:0]                   i_retire_tag,
    output logic [OPTN_DATA_WIDTH-1:0]                      o_data,
    output logic [OPTN_ROB_IDX_WIDTH-1:0]                   o_tag,
    output logic                                            o_rdy
);

    logic [OPTN_DATA_WIDTH-1:0]    data_arr [OPTN_REGMAP_DEPTH];
    logic [OPTN_ROB_IDX_WIDTH-1:0] tag_arr  [OPTN_REGMAP_DEPTH];

    // Unpack the flattened entry buses so the mux can index by register number
    generate
        for (genvar gi = 0; gi < OPTN_REGMAP_DEPTH; gi++) begin : g_unpack
            assign data_arr[gi] = i_rat_data[gi*OPTN_DATA_WIDTH +: OPTN_DATA_WIDTH];
            assign tag_arr[gi]  = i_rat_tag[gi*OPTN_ROB_IDX_WIDTH +: OPTN_ROB_IDX_WIDTH];
        end
    endgenerate

    logic is_x0;
    logic bypass_hit;

    assign is_x0      = (i_rs == '0);
    assign bypass_hit = i_retire_en & (i_retire_rdest == i_rs) & ~is_x0 &
                        (i_retire_tag == tag_arr[i_rs]);

    // Select entry contents, then override for x0 or a matching retire
    always_comb begin
        o_data = data_arr[i_rs];
        o_tag  = tag_arr[i_rs];
        o_rdy  = i_rat_rdy[i_rs];
        if (is_x0) begin
            o_data = '0;
            o_tag  = '0;
            o_rdy  = 1'b1;
        end else if (bypass_hit) begin
            o_data = i_retire_data;
            o_rdy  = 1'b1;
        end
    end

endmodule

// File: rtl/procyon_rat_ctrl.sv
// RAT entry-array controller: decodes rename/retire into one-hot entry enables
// (x0 never written), serves two source lookups, and sequences flush recovery
// by pulsing the entry flush and then holding rename off for a drain window.
module procyon_rat_ctrl
    import procyon_core_pkg::*;
#(
    parameter int OPTN_DATA_WIDTH    = 32,
    parameter int OPTN_ROB_IDX_WIDTH = 5,
    parameter int OPTN_REGMAP_DEPTH  = 32,
    parameter int OPTN_FLUSH_STALL   = 2,
    localparam int IDX_W = regmap_idx_width(OPTN_REGMAP_DEPTH)
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            i_flush_req,
    input  logic                                            i_rename_valid,
    output logic                                            o_rename_ready,
    input  logic [IDX_W-1:0]                                i_rename_rdest,
    input  logic [OPTN_ROB_IDX_WIDTH-1:0]                   i_rename_tag,
    input  logic                                            i_retire_en,
    input  logic [IDX_W-1:0]                                i_retire_rdest,
    input  logic [OPTN_DATA_WIDTH-1:0]                      i_retire_data,
    input  logic [OPTN_ROB_IDX_WIDTH-1:0]                   i_retire_tag,
    input  logic [IDX_W-1:0]                                i_rs1,
    input  logic [IDX_W-1:0]                                i_rs2,
    output logic [OPTN_DATA_WIDTH-1:0]                      o_rs1_data,
    output logic [OPTN_DATA_WIDTH-1:0]                      o_rs2_data,
    output logic [OPTN_ROB_IDX_WIDTH-1:0]                   o_rs1_tag,
    output logic [OPTN_ROB_IDX_WIDTH-1:0]                   o_rs2_tag,
    output logic                                            o_rs1_rdy,
    output logic                                            o_rs2_rdy,
    output logic                                            o_rat_flush,
    output logic [OPTN_REGMAP_DEPTH-1:0]                    o_rat_rename_en,
    output logic [OPTN_ROB_IDX_WIDTH-1:0]                   o_rat_rename_tag,
    output logic [OPTN_REGMAP_DEPTH-1:0]                    o_rat_retire_en,
    output logic [OPTN_DATA_WIDTH-1:0]                      o_rat_retire_data,
    output logic [OPTN_ROB_IDX_WIDTH-1:0]                   o_rat_retire_tag,
    input  logic [OPTN_REGMAP_DEPTH*OPTN_DATA_WIDTH-1:0]    i_rat_data,
    input  logic [OPTN_REGMAP_DEPTH*OPTN_ROB_IDX_WIDTH-1:0] i_rat_tag,
    input  logic [OPTN_REGMAP_DEPTH-1:0]                    i_rat_rdy
);

    localparam int CNT_W = (OPTN_FLUSH_STALL > 1) ? $clog2(OPTN_FLUSH_STALL) : 1;
    localparam logic [CNT_W-1:0] STALL_INIT = CNT_W'(OPTN_FLUSH_STALL - 1);

    rat_ctrl_state_t  state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             flush_reg;

    // State, drain counter and flush pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            flush_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            flush_reg <= (state_next == FLUSH);
        end
    end

    // Next-state logic; a new flush request restarts recovery from any state
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (i_flush_req) state_next = FLUSH;
            end
            FLUSH: begin
                cnt_next   = STALL_INIT;
                state_next = i_flush_req ? FLUSH : DRAIN;
            end
            DRAIN: begin
                if (i_flush_req) begin
                    state_next = FLUSH;
                end else if (cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    logic rename_fire;

    assign o_rename_ready = (state_reg == IDLE) & ~i_flush_req & ~rst;
    assign rename_fire    = i_rename_valid & o_rename_ready;
    assign o_rat_flush    = flush_reg;

    // Broadcast buses go straight to every entry; the one-hot enables select
    assign o_rat_rename_tag  = i_rename_tag;
    assign o_rat_retire_data = i_retire_data;
    assign o_rat_retire_tag  = i_retire_tag;

    // Per-entry enable decode; entry 0 (x0) is hardwired and never written
    generate
        for (genvar gi = 0; gi < OPTN_REGMAP_DEPTH; gi++) begin : g_en
            if (gi == 0) begin : g_x0
                assign o_rat_rename_en[gi] = 1'b0;
                assign o_rat_retire_en[gi] = 1'b0;
            end else begin : g_reg
                localparam logic [IDX_W-1:0] IDX = IDX_W'(gi);
                assign o_rat_rename_en[gi] = rename_fire & (i_rename_rdest == IDX);
                assign o_rat_retire_en[gi] = i_retire_en & ~rst & (i_retire_rdest == IDX);
            end
        end
    endgenerate

    procyon_rat_lookup #(
        .OPTN_DATA_WIDTH    (OPTN_DATA_WIDTH),
        .OPTN_ROB_IDX_WIDTH (OPTN_ROB_IDX_WIDTH),
        .OPTN_REGMAP_DEPTH  (OPTN_REGMAP_DEPTH)
    ) u_lookup_rs1 (
        .i_rs           (i_rs1),
        .i_rat_data     (i_rat_data),
        .i_rat_tag      (i_rat_tag),
        .i_rat_rdy      (i_rat_rdy),
        .i_retire_en    (i_retire_en),
        .i_retire_rdest (i_retire_rdest),
        .i_retire_data  (i_retire_data),
        .i_retire_tag   (i_retire_tag),
        .o_data         (o_rs1_data),
        .o_tag          (o_rs1_tag),
        .o_rdy          (o_rs1_rdy)
    );

    procyon_rat_lookup #(
        .OPTN_DATA_WIDTH    (OPTN_DATA_WIDTH),
        .OPTN_ROB_IDX_WIDTH (OPTN_ROB_IDX_WIDTH),
        .OPTN_REGMAP_DEPTH  (OPTN_REGMAP_DEPTH)
    ) u_lookup_rs2 (
        .i_rs           (i_rs2),
        .i_rat_data     (i_rat_data),
        .i_rat_tag      (i_rat_tag),
        .i_rat_rdy      (i_rat_rdy),
        .i_retire_en    (i_retire_en),
        .i_retire_rdest (i_retire_rdest),
        .i_retire_data  (i_retire_data),
        .i_retire_tag   (i_retire_tag),
        .o_data         (o_rs2_data),
        .o_tag          (o_rs2_tag),
        .o_rdy          (o_rs2_rdy)
    );

endmodule
